fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I core, directly upstream of `control_unit`. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched instruction and its PC stable for decode and execute. It advances only when downstream consumes the instruction, selecting PC+4 or PC+ImmOp using the `PCsrc` decision returned by `control_unit`.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_pc_next.sv | 21 ++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_ERROR
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential PC+4 or branch target, with alignment flag.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  PCsrc,
  output logic [ADDR_WIDTH-1:0] next,
  output logic                  misaligned
);

  // Modulo-2^ADDR_WIDTH add; wrap-around is a legal target.
  always_comb begin
    next       = PCsrc ? (pc + ImmOp[ADDR_WIDTH-1:0]) : (pc + ADDR_WIDTH'(PC_INCR));
    misaligned = |next[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, holds instr for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ack,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  instr_valid,
  output logic                  fetch_err
);

  fetch_state_t          state, state_nx;
  logic [ADDR_WIDTH-1:0] pc_nx;
  logic [ADDR_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] instr_nx;
  logic                  target_misaligned;

  pc_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_next (
    .pc         (pc),
    .ImmOp      (ImmOp),
    .PCsrc      (PCsrc),
    .next       (target),
    .misaligned (target_misaligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and next-datapath decode; acks outside FETCH are ignored.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    unique case (state)
      ST_IDLE:  state_nx = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_nx = imem_rdata;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          if (target_misaligned) begin
            state_nx = ST_ERROR;
          end else begin
            pc_nx    = target;
            state_nx = ST_FETCH;
          end
        end
      end
      ST_ERROR: state_nx = ST_ERROR;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Registered datapath and status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= DATA_WIDTH'(NOP_INSTR);
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      pc          <= pc_nx;
      instr       <= instr_nx;
      imem_req    <= (state_nx == ST_FETCH);
      instr_valid <= (state_nx == ST_HOLD);
      fetch_err   <= (state_nx == ST_ERROR);
    end
  end

  // Request address always tracks the held PC register.
  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCsrc = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the stage is doing, in terms of a pending request,
  // a held instruction or a halt; updated from the inputs seen at each edge.
  logic        m_boot  = 1'b1;  // one idle cycle after reset before requesting
  logic        m_req   = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_tgt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_pc = RST_PC; m_instr = NOP;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_req   = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_valid && !stall) begin
      m_tgt   = PCsrc ? (m_pc + ImmOp) : (m_pc + 32'd4);
      m_valid = 1'b0;
      if ((m_tgt % 4) != 0) begin
        m_err = 1'b1;
      end else begin
        m_pc  = m_tgt;
        m_req = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model imem_req", 32'(imem_req), 32'(m_req));
    check("model imem_addr", imem_addr, m_pc);
    check("model pc", pc, m_pc);
    check("model instr", instr, m_instr);
    check("model instr_valid", 32'(instr_valid), 32'(m_valid));
    check("model fetch_err", 32'(fetch_err), 32'(m_err));
  end

  // Wait (bounded) for a request, return data with one ack, park in HOLD.
  task automatic fetch_hold(input logic [31:0] data);
    int n;
    n = 0;
    stall = 1'b1;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check("request seen", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    check("fetched instr", instr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt;
    int consumed;
    logic [31:0] r;
    wcnt = 0;
    consumed = 0;

    // Reset values.
    step(); step();
    check("reset imem_req", 32'(imem_req), 32'd0);
    check("reset instr_valid", 32'(instr_valid), 32'd0);
    check("reset fetch_err", 32'(fetch_err), 32'd0);
    check("reset pc", pc, 32'hBFC0_0000);
    check("reset instr", instr, 32'h0000_0013);

    // Release: cycle 0 idle, cycle 1 request, zero-wait ack, valid in cycle 2.
    rst_n = 1'b1;
    check("idle no req", 32'(imem_req), 32'd0);
    step();
    check("c1 imem_req", 32'(imem_req), 32'd1);
    check("c1 imem_addr", imem_addr, 32'hBFC0_0000);
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0;
    check("c2 instr_valid", 32'(instr_valid), 32'd1);
    check("c2 instr", instr, 32'h0050_0093);
    check("c2 pc", pc, 32'hBFC0_0000);
    stall = 1'b0;
    PCsrc = 1'b0;
    step();
    check("c3 imem_addr", imem_addr, 32'hBFC0_0004);
    check("c3 imem_req", 32'(imem_req), 32'd1);

    // Three wait cycles: request stable across all four FETCH cycles.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("wait req stable", 32'(imem_req), 32'd1);
      check("wait addr stable", imem_addr, 32'hBFC0_0004);
      step();
    end
    check("ack cycle req", 32'(imem_req), 32'd1);
    check("ack cycle addr", imem_addr, 32'hBFC0_0004);
    check("ack cycle not valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 1'b0;
    check("post ack valid", 32'(instr_valid), 32'd1);
    check("post ack instr", instr, 32'h1111_1111);

    // Stall for five cycles in HOLD.
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall instr", instr, 32'h1111_1111);
      check("stall pc", pc, 32'hBFC0_0004);
      check("stall no req", 32'(imem_req), 32'd0);
      check("stall valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    check("release addr", imem_addr, 32'hBFC0_0008);
    check("release req", 32'(imem_req), 32'd1);

    // Walk to 0xBFC00010, then branch backwards by 8.
    fetch_hold(32'hA000_0001);
    stall = 1'b0; step();
    fetch_hold(32'hA000_0002);
    stall = 1'b0; step();
    fetch_hold(32'hA000_0003);
    check("branch source pc", pc, 32'hBFC0_0010);
    stall = 1'b0;
    PCsrc = 1'b1;
    ImmOp = 32'hFFFF_FFF8;
    step();
    PCsrc = 1'b0;
    check("branch target", imem_addr, 32'hBFC0_0008);

    // Misaligned target halts the stage.
    fetch_hold(32'hA000_0004);
    stall = 1'b0;
    PCsrc = 1'b1;
    ImmOp = 32'h0000_0006;
    step();
    PCsrc = 1'b0;
    stall = 1'b1;
    check("err fetch_err", 32'(fetch_err), 32'd1);
    check("err instr_valid", 32'(instr_valid), 32'd0);
    check("err no req", 32'(imem_req), 32'd0);
    check("err keeps pc", pc, 32'hBFC0_0008);
    imem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("err sticky", 32'(fetch_err), 32'd1);
      check("err stray ack no req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset clears err", 32'(fetch_err), 32'd0);
    check("async reset pc", pc, 32'hBFC0_0000);
    step();
    rst_n = 1'b1;
    step();
    check("refetch req", 32'(imem_req), 32'd1);
    check("refetch addr", imem_addr, 32'hBFC0_0000);

    // Reset mid-FETCH drops the request at once; a late ack is ignored.
    rst_n = 1'b0;
    #1;
    check("mid-fetch reset drops req", 32'(imem_req), 32'd0);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("late ack req", 32'(imem_req), 32'd1);
    check("late ack not valid", 32'(instr_valid), 32'd0);
    step();
    check("late ack instr", instr, 32'h0000_0013);
    check("late ack still fetching", 32'(instr_valid), 32'd0);

    // Jump to the top word, then sequential wrap to zero.
    fetch_hold(32'h0000_0013);
    stall = 1'b0;
    PCsrc = 1'b1;
    ImmOp = 32'h403F_FFFC;
    step();
    PCsrc = 1'b0;
    check("top word addr", imem_addr, 32'hFFFF_FFFC);
    fetch_hold(32'h0000_0033);
    stall = 1'b0;
    step();
    check("wrap addr", imem_addr, 32'h0000_0000);
    check("wrap no err", 32'(fetch_err), 32'd0);
    check("wrap req", 32'(imem_req), 32'd1);

    // Randomized traffic: wait states, stalls, branches, stray acks, resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      stall = ($urandom_range(3) == 0);
      PCsrc = 1'($urandom_range(1));
      ImmOp = ($urandom_range(39) == 0) ? r : {{19{r[12]}}, r[12:2], 2'b00};
      imem_rdata = $urandom;
      if (imem_req) begin
        imem_ack = (wcnt == 0);
        if (wcnt == 0) wcnt = $urandom_range(3);
        else           wcnt--;
      end else begin
        imem_ack = ($urandom_range(7) == 0);
      end
      if (instr_valid && !stall) consumed++;
      if (fetch_err || $urandom_range(499) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end
    check("random progress", 32'(consumed > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
